wb_arbiter_2to1: RTL and testbench
==================================

Name: wb_arbiter_2to1

Overview:
Two-master to one-slave pipelined Wishbone (B4) arbiter. It sits directly downstream of two Ibex core-to-Wishbone converters (instruction port on m0, data port on m1) and feeds a single slave or interconnect port. The grant is held for a whole CYC cycle. A bus-timeout watchdog terminates hung transfers with an error.

Parameters:
ROUND_ROBIN, 1, 1 = round-robin between masters; 0 = fixed priority, m0 wins.
TIMEOUT, 255, maximum cycles a granted CYC may wait for ack/err before abort; 0 disables the watchdog.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
mX_cyc_i, mX_stb_i, mX_we_i  in  1 each  master X (X=0,1) cycle, strobe, write enable
mX_adr_i  in  28  master X word address
mX_sel_i  in  4  master X byte select
mX_dat_i  in  32  master X write data
mX_dat_o  out  32  read data to master X (s_dat_i broadcast to both)
mX_ack_o, mX_err_o, mX_stall_o  out  1 each  master X ack, error, stall
s_cyc_o, s_stb_o, s_we_o  out  1 each  slave cycle, strobe, write enable
s_adr_o  out  28  slave word address
s_sel_o  out  4  slave byte select
s_dat_o  out  32  slave write data
s_dat_i  in  32  slave read data
s_ack_i, s_err_i, s_stall_i  in  1 each  slave ack, error, stall
timeout_o  out  1  one-cycle pulse when the watchdog aborts a transfer

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE, last_grant=1 (m0 wins first tie), timeout counter=0.
  - s_cyc_o=s_stb_o=0, mX_ack_o=mX_err_o=0, mX_stall_o=1, timeout_o=0.
  - s_we_o/s_adr_o/s_sel_o/s_dat_o follow the m0 mux (don't-care).
- States: IDLE, GNT0, GNT1, ABORT. The grant is registered.
- IDLE:
  - Both stalls =1; s_cyc_o=0.
  - If exactly one mX_cyc_i=1, go to GNTX next edge.
  - If both request: ROUND_ROBIN=1 grants the master != last_grant; ROUND_ROBIN=0 grants m0.
  - On grant, last_grant<=X.
  - Arbitration latency is 1 cycle: a request at edge N reaches the slave at edge N+1.
- GNTX:
  - s_cyc_o=mX_cyc_i; s_stb_o/we/adr/sel/dat_o = master X signals (combinational mux).
  - mX_stall_o=s_stall_i, mX_ack_o=s_ack_i, mX_err_o=s_err_i.
  - The other master sees stall=1, ack=0, err=0.
  - When mX_cyc_i=0, go to IDLE next edge; s_cyc_o drops in that same cycle.
  - No re-arbitration while mX_cyc_i=1, including multiple transfers within one CYC.
- Watchdog (TIMEOUT>0):
  - Counter clears on entry to GNTX and on any cycle with s_ack_i|s_err_i.
  - Otherwise it increments while in GNTX with mX_cyc_i=1.
  - When the counter equals TIMEOUT, the state goes to ABORT on the next edge.
  - The counter saturates; it never wraps.
- ABORT (granted master X):
  - s_cyc_o=s_stb_o=0 (slave released).
  - In the first ABORT cycle, mX_err_o=1 and timeout_o=1; both are 0 afterwards.
  - mX_stall_o=1; the remaining master is stalled.
  - Stay in ABORT until mX_cyc_i=0, then go to IDLE.
  - Late s_ack_i/s_err_i are ignored.
- Simultaneous events:
  - s_ack_i and the counter reaching TIMEOUT in the same cycle: the ack wins, the counter clears, and there is no abort.
  - A master dropping cyc while the other requests: IDLE is visited for one cycle, then the other master is granted.
- Reset mid-transfer: outputs return to reset values immediately (asynchronously). Masters see no ack.
- mX_ack_o, mX_err_o and timeout_o are never 1 for an ungranted master.

Test Plan:
- Single read, m1 only: m1 cyc/stb, adr=0x0000010, slave ack 2 cycles after s_stb -> s_stb_o rises 1 cycle after m1 request; m1_ack_o with m1_dat_o=s_dat_i=0xDEADBEEF; m0_stall_o stays 1.
- Simultaneous requests, ROUND_ROBIN=1, back-to-back: first grant m0, then m1, then m0 again when both re-request -> grants alternate; with ROUND_ROBIN=0, m0 wins all three.
- Slave stall: s_stall_i=1 for 3 cycles during GNT0 -> m0_stall_o=1 for exactly those 3 cycles; s_stb_o held; a write of sel=4'b0011, dat=0x12345678 reaches the slave unchanged.
- Watchdog, TIMEOUT=4: slave never acks -> ABORT entered after 5 GNT cycles; single-cycle m0_err_o and timeout_o pulse; s_cyc_o=0; after m0 drops cyc, a pending m1 is granted.
- Ack coincident with the timeout threshold -> normal ack, timeout_o stays 0.
- Assert rst_ni low mid-transfer in GNT1 -> s_cyc_o=0 and both stalls=1 immediately; after release, the first tie is granted to m0.

Source files
------------

// File: rtl/wb_arbiter_2to1.sv
// Two-master to one-slave pipelined Wishbone B4 arbiter. The grant is held for a
// whole CYC, and a watchdog aborts hung transfers with a single-cycle error.
module wb_arbiter_2to1 #(
  parameter bit          ROUND_ROBIN = 1'b1,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [27:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_stall_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [27:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_stall_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [27:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_stall_i,
  output logic        timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

  state_t           state_reg, state_next;
  logic             last_grant_reg, last_grant_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             abort_first_reg, abort_first_next;
  logic             gnt_cyc;
  logic             cnt_hit;
  logic [1:0]       pass_vec;
  logic [1:0]       ack_vec, err_vec, stall_vec;

  // last_grant always names the owner while in GNT0/GNT1/ABORT
  assign gnt_cyc = last_grant_reg ? m1_cyc_i : m0_cyc_i;
  assign cnt_hit = (TIMEOUT != 0) && (cnt_reg == CNT_W'(TIMEOUT));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg       <= IDLE;
      last_grant_reg  <= 1'b1;
      cnt_reg         <= '0;
      abort_first_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      last_grant_reg  <= last_grant_next;
      cnt_reg         <= cnt_next;
      abort_first_reg <= abort_first_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    last_grant_next  = last_grant_reg;
    cnt_next         = '0;
    abort_first_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          if (ROUND_ROBIN && !last_grant_reg) begin
            state_next      = GNT1;
            last_grant_next = 1'b1;
          end else begin
            state_next      = GNT0;
            last_grant_next = 1'b0;
          end
        end else if (m0_cyc_i) begin
          state_next      = GNT0;
          last_grant_next = 1'b0;
        end else if (m1_cyc_i) begin
          state_next      = GNT1;
          last_grant_next = 1'b1;
        end
      end
      GNT0, GNT1: begin
        if (!gnt_cyc) begin
          state_next = IDLE;
        end else if (s_ack_i || s_err_i) begin
          cnt_next = '0;
        end else if (cnt_hit) begin
          state_next       = ABORT;
          abort_first_next = 1'b1;
        end else begin
          // saturating: only reachable past TIMEOUT when the watchdog is off
          cnt_next = (cnt_reg != '1) ? cnt_reg + CNT_W'(1) : cnt_reg;
        end
      end
      ABORT: begin
        if (!gnt_cyc) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign pass_vec = {state_reg == GNT1, state_reg == GNT0};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_resp
      logic owner;
      assign owner         = (gi == 1) ? last_grant_reg : ~last_grant_reg;
      assign ack_vec[gi]   = pass_vec[gi] & s_ack_i;
      assign err_vec[gi]   = (pass_vec[gi] & s_err_i) | (abort_first_reg & owner);
      assign stall_vec[gi] = pass_vec[gi] ? s_stall_i : 1'b1;
    end
  endgenerate

  assign m0_ack_o   = ack_vec[0];
  assign m0_err_o   = err_vec[0];
  assign m0_stall_o = stall_vec[0];
  assign m1_ack_o   = ack_vec[1];
  assign m1_err_o   = err_vec[1];
  assign m1_stall_o = stall_vec[1];
  assign m0_dat_o   = s_dat_i;
  assign m1_dat_o   = s_dat_i;
  assign timeout_o  = abort_first_reg;

  assign s_cyc_o = (pass_vec[0] & m0_cyc_i) | (pass_vec[1] & m1_cyc_i);
  assign s_stb_o = (pass_vec[0] & m0_stb_i) | (pass_vec[1] & m1_stb_i);
  assign s_we_o  = pass_vec[1] ? m1_we_i  : m0_we_i;
  assign s_adr_o = pass_vec[1] ? m1_adr_i : m0_adr_i;
  assign s_sel_o = pass_vec[1] ? m1_sel_i : m0_sel_i;
  assign s_dat_o = pass_vec[1] ? m1_dat_i : m0_dat_i;

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Directed bench for wb_arbiter_2to1: a round-robin and a fixed-priority instance
// share stimulus; a per-cycle vector table plus a reset-mid-transfer sequence.
module tb_wb_arbiter_2to1;

  localparam logic [27:0] M0_ADR = 28'h0000100;
  localparam logic [27:0] M1_ADR = 28'h0000010;
  localparam logic [31:0] M0_DAT = 32'h12345678;
  localparam logic [31:0] M1_DAT = 32'hCAFEF00D;
  localparam logic [3:0]  M0_SEL = 4'b0011;
  localparam logic [3:0]  M1_SEL = 4'b1111;
  localparam logic [31:0] S_DAT  = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m0_cyc = 0, m0_stb = 0, m1_cyc = 0, m1_stb = 0;
  logic s_ack = 0, s_err = 0, s_stall = 0;

  logic [31:0] m0_dat_o, m1_dat_o, s_dat_o;
  logic        m0_ack_o, m0_err_o, m0_stall_o, m1_ack_o, m1_err_o, m1_stall_o;
  logic        s_cyc_o, s_stb_o, s_we_o, timeout_o;
  logic [27:0] s_adr_o;
  logic [3:0]  s_sel_o;

  logic [31:0] fp_m0_dat_o, fp_m1_dat_o, fp_s_dat_o;
  logic        fp_m0_ack_o, fp_m0_err_o, fp_m0_stall_o, fp_m1_ack_o, fp_m1_err_o, fp_m1_stall_o;
  logic        fp_s_cyc_o, fp_s_stb_o, fp_s_we_o, fp_timeout_o;
  logic [27:0] fp_s_adr_o;
  logic [3:0]  fp_s_sel_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_arbiter_2to1 #(.ROUND_ROBIN(1'b1), .TIMEOUT(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(1'b1), .m0_adr_i(M0_ADR),
    .m0_sel_i(M0_SEL), .m0_dat_i(M0_DAT), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_stall_o(m0_stall_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(1'b0), .m1_adr_i(M1_ADR),
    .m1_sel_i(M1_SEL), .m1_dat_i(M1_DAT), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_stall_o(m1_stall_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(S_DAT),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_stall_i(s_stall), .timeout_o(timeout_o)
  );

  wb_arbiter_2to1 #(.ROUND_ROBIN(1'b0), .TIMEOUT(4)) dut_fp (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(1'b1), .m0_adr_i(M0_ADR),
    .m0_sel_i(M0_SEL), .m0_dat_i(M0_DAT), .m0_dat_o(fp_m0_dat_o),
    .m0_ack_o(fp_m0_ack_o), .m0_err_o(fp_m0_err_o), .m0_stall_o(fp_m0_stall_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(1'b0), .m1_adr_i(M1_ADR),
    .m1_sel_i(M1_SEL), .m1_dat_i(M1_DAT), .m1_dat_o(fp_m1_dat_o),
    .m1_ack_o(fp_m1_ack_o), .m1_err_o(fp_m1_err_o), .m1_stall_o(fp_m1_stall_o),
    .s_cyc_o(fp_s_cyc_o), .s_stb_o(fp_s_stb_o), .s_we_o(fp_s_we_o), .s_adr_o(fp_s_adr_o),
    .s_sel_o(fp_s_sel_o), .s_dat_o(fp_s_dat_o), .s_dat_i(S_DAT),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_stall_i(s_stall), .timeout_o(fp_timeout_o)
  );

  // in_bits  = {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err, s_stall}
  // exp_bits = {s_cyc, s_stb, m0_stall, m0_ack, m0_err, m1_stall, m1_ack, m1_err, timeout}
  // asel/fsel: slave mux expected on m1 for the round-robin / fixed-priority instance
  typedef struct {
    logic [6:0] in_bits;
    logic [8:0] exp_bits;
    logic       asel;
    logic       fsel;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic [6:0] in_bits, logic [8:0] exp_bits, logic asel, logic fsel);
    vec_t v;
    v.in_bits  = in_bits;
    v.exp_bits = exp_bits;
    v.asel     = asel;
    v.fsel     = fsel;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    // single read on m1, slave acks two cycles after the strobe
    add(7'b0011000, 9'b001001000, 0, 0);  // 0  IDLE, m1 requests
    add(7'b0011000, 9'b111000000, 1, 1);  // 1  GNT1, strobe reaches slave
    add(7'b0010000, 9'b101000000, 1, 1);  // 2
    add(7'b0010100, 9'b101000100, 1, 1);  // 3  ack to m1
    add(7'b0000000, 9'b001000000, 1, 1);  // 4  m1 drops cyc
    add(7'b0000000, 9'b001001000, 0, 0);  // 5  IDLE
    // ties under round-robin: m0, then m1, then m0
    add(7'b1111000, 9'b001001000, 0, 0);  // 6  tie
    add(7'b1111000, 9'b110001000, 0, 0);  // 7  GNT0
    add(7'b1011010, 9'b100011000, 0, 0);  // 8  slave err to m0
    add(7'b0011000, 9'b000001000, 0, 0);  // 9  m0 drops
    add(7'b1111000, 9'b001001000, 0, 0);  // 10 tie
    add(7'b1111000, 9'b111000000, 1, 0);  // 11 GNT1 (fixed priority holds m0)
    add(7'b1110100, 9'b101000100, 1, 0);  // 12 ack to m1
    add(7'b1100000, 9'b001000000, 1, 0);  // 13 m1 drops
    add(7'b1111000, 9'b001001000, 0, 0);  // 14 tie
    add(7'b1100000, 9'b110001000, 0, 0);  // 15 GNT0
    add(7'b1000100, 9'b100101000, 0, 0);  // 16 ack to m0
    add(7'b0000000, 9'b000001000, 0, 0);  // 17 m0 drops
    // slave stall for 3 cycles, then ack lands exactly at the timeout threshold
    add(7'b1100000, 9'b001001000, 0, 0);  // 18
    add(7'b1100001, 9'b111001000, 0, 0);  // 19
    add(7'b1100001, 9'b111001000, 0, 0);  // 20
    add(7'b1100001, 9'b111001000, 0, 0);  // 21
    add(7'b1100000, 9'b110001000, 0, 0);  // 22
    add(7'b1000100, 9'b100101000, 0, 0);  // 23 ack with counter == TIMEOUT
    add(7'b0000000, 9'b000001000, 0, 0);  // 24
    // watchdog: slave never answers, m1 pending
    add(7'b1100000, 9'b001001000, 0, 0);  // 25
    add(7'b1111000, 9'b110001000, 0, 0);  // 26 GNT0 count 0
    add(7'b1011000, 9'b100001000, 0, 0);  // 27
    add(7'b1011000, 9'b100001000, 0, 0);  // 28
    add(7'b1011000, 9'b100001000, 0, 0);  // 29
    add(7'b1011000, 9'b100001000, 0, 0);  // 30 count == TIMEOUT
    add(7'b1011000, 9'b001011001, 0, 0);  // 31 ABORT first cycle
    add(7'b1011100, 9'b001001000, 0, 0);  // 32 late ack ignored
    add(7'b0011000, 9'b001001000, 0, 0);  // 33 m0 releases
    add(7'b0011000, 9'b001001000, 0, 0);  // 34 IDLE
    add(7'b0011000, 9'b111000000, 1, 1);  // 35 GNT1

    #2;
    chk("rst_s_cyc", {31'd0, s_cyc_o}, 32'd0);
    chk("rst_stalls", {30'd0, m0_stall_o, m1_stall_o}, 32'd3);
    chk("rst_timeout", {31'd0, timeout_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err, s_stall} = vecs[i].in_bits;
      #1;
      chk($sformatf("row%0d_ctl", i),
          {23'd0, s_cyc_o, s_stb_o, m0_stall_o, m0_ack_o, m0_err_o,
           m1_stall_o, m1_ack_o, m1_err_o, timeout_o},
          {23'd0, vecs[i].exp_bits});
      chk($sformatf("row%0d_adr", i), {4'd0, s_adr_o}, {4'd0, vecs[i].asel ? M1_ADR : M0_ADR});
      chk($sformatf("row%0d_fp_adr", i), {4'd0, fp_s_adr_o}, {4'd0, vecs[i].fsel ? M1_ADR : M0_ADR});
      if (vecs[i].exp_bits[8]) begin
        chk($sformatf("row%0d_dat", i), s_dat_o, vecs[i].asel ? M1_DAT : M0_DAT);
        chk($sformatf("row%0d_sel_we", i), {27'd0, s_sel_o, s_we_o},
            {27'd0, vecs[i].asel ? {M1_SEL, 1'b0} : {M0_SEL, 1'b1}});
      end
      if (vecs[i].exp_bits[2])
        chk($sformatf("row%0d_m1_dat", i), m1_dat_o, S_DAT);
    end

    // reset mid-transfer in GNT1: outputs fall back immediately, no ack leaks
    @(negedge clk);
    s_ack = 1'b1;
    #1;
    chk("gnt1_ack", {31'd0, m1_ack_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_s_cyc", {31'd0, s_cyc_o}, 32'd0);
    chk("midrst_stalls", {30'd0, m0_stall_o, m1_stall_o}, 32'd3);
    chk("midrst_m1_ack", {31'd0, m1_ack_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    s_ack = 1'b0;
    {m0_cyc, m0_stb, m1_cyc, m1_stb} = 4'b1111;
    #1;
    chk("post_rst_idle", {31'd0, s_cyc_o}, 32'd0);
    @(negedge clk);
    #1;
    chk("post_rst_tie_cyc", {31'd0, s_cyc_o}, 32'd1);
    chk("post_rst_tie_adr", {4'd0, s_adr_o}, {4'd0, M0_ADR});
    chk("post_rst_tie_stalls", {30'd0, m0_stall_o, m1_stall_o}, 32'd1);
    {m0_cyc, m0_stb, m1_cyc, m1_stb} = 4'b0000;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
